// File: rtl/wallace_mac_unit.sv
// Multiply-accumulate stage around a 4x4 Wallace-tree multiplier (signed A, unsigned B).
// Optional macro WALLACE_MAC_SAT_EN: the accumulator clamps on signed overflow instead of wrapping.

module wallace_mul4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_a_ext;
  logic [7:0] w_pp0, w_pp1, w_pp2, w_pp3;
  logic [7:0] w_s1, w_c1, w_s2, w_c2;

  // A is sign-extended so that every partial-product row is correct modulo 2^8.
  assign w_a_ext = {{4{i_a[3]}}, i_a};
  assign w_pp0   = i_b[0] ? w_a_ext                 : 8'd0;
  assign w_pp1   = i_b[1] ? {w_a_ext[6:0], 1'b0}    : 8'd0;
  assign w_pp2   = i_b[2] ? {w_a_ext[5:0], 2'b00}   : 8'd0;
  assign w_pp3   = i_b[3] ? {w_a_ext[4:0], 3'b000}  : 8'd0;

  // The first carry-save layer turns rows 0..2 into a sum and a carry. The second layer folds in row 3.
  assign w_s1 = w_pp0 ^ w_pp1 ^ w_pp2;
  assign w_c1 = {((w_pp0[6:0] & w_pp1[6:0]) | (w_pp0[6:0] & w_pp2[6:0]) |
                  (w_pp1[6:0] & w_pp2[6:0])), 1'b0};
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp3;
  assign w_c2 = {((w_s1[6:0] & w_c1[6:0]) | (w_s1[6:0] & w_pp3[6:0]) |
                  (w_c1[6:0] & w_pp3[6:0])), 1'b0};
  assign o_p  = w_s2 + w_c2;
endmodule

module wallace_mac_unit #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic [1:0]       o_dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready. A producer holds valid
  // and data until that edge. Ready may depend on state but never on valid.

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            r_state, w_state_next;
  logic              r_s1_valid, r_s1_last;
  logic [3:0]        r_s1_a, r_s1_b;
  logic              r_s2_valid, r_s2_last;
  logic [7:0]        r_s2_prod;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_count;
  logic              r_ovf;

  logic              w_accept;
  logic              w_result_take;
  logic [7:0]        w_prod;
  logic signed [7:0] w_prod_s;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_add_ovf;
  logic [ACC_W-1:0]  w_acc_next;

  wallace_mul4x4 u_mul (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_s2_valid && r_s2_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign w_accept      = in_valid && in_ready;
  assign w_result_take = out_valid && out_ready;

  // Operand and product data registers load only on a valid transfer. The valid bits gate all use.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a    <= in_a;
      r_s1_b    <= in_b;
      r_s1_last <= in_last;
    end
    if (r_s1_valid) begin
      r_s2_prod <= w_prod;
      r_s2_last <= r_s1_last;
    end
  end

  assign w_prod_s   = r_s2_prod;
  assign w_prod_ext = ACC_W'(w_prod_s);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef WALLACE_MAC_SAT_EN
  assign w_acc_next = w_add_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
  assign w_acc_next = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst || w_result_take) begin
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else if (r_s2_valid) begin
      r_acc   <= w_acc_next;
      r_count <= (r_count == 8'd255) ? r_count : r_count + 8'd1;
      if (w_add_ovf) r_ovf <= 1'b1;
    end
  end

  assign out_acc     = r_acc;
  assign out_count   = r_count;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_wallace_mac_unit.sv
// Directed self-checking bench for wallace_mac_unit: a 16-bit instance and an 8-bit overflow instance.
`timescale 1ns/1ps

module tb_wallace_mac_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [3:0]  in_a, in_b;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_acc;
  logic [7:0]  out_count;
  logic [1:0]  dbg_state;

  logic        in_valid8, in_last8, out_ready8;
  logic [3:0]  in_a8, in_b8;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [7:0]  out_acc8;
  logic [7:0]  out_count8;
  logic [1:0]  dbg_state8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_mac_unit #(.ACC_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .o_dbg_state(dbg_state)
  );

  wallace_mac_unit #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .in_last(in_last8), .out_valid(out_valid8), .out_ready(out_ready8), .out_acc(out_acc8),
    .out_count(out_count8), .out_ovf(out_ovf8), .o_dbg_state(dbg_state8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic last);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL beat_in_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_beat8(input logic [3:0] a, input logic [3:0] b, input logic last);
    in_a8 = a; in_b8 = b; in_last8 = last; in_valid8 = 1'b1;
    checks++;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL beat8_in_ready got %b exp 1", in_ready8); end
    step();
    in_valid8 = 1'b0; in_last8 = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin step(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_valid got %b exp 1 (timeout)", out_valid); end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL take_out_valid got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL take_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_acc !== 16'h0000) begin errors++; $display("FAIL rst_out_acc got %h exp 0000", out_acc); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got %b exp 0", out_ovf); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_single();
    send_beat(4'b1101, 4'd5, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0 got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_drop got %b exp 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1 got %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2 got %b exp 1", out_valid); end
    checks++; if (out_acc !== 16'hFFF1) begin errors++; $display("FAIL single_acc got %h exp fff1", out_acc); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b exp 0", out_ovf); end
    take_result();
    checks++; if (out_acc !== 16'h0000) begin errors++; $display("FAIL single_acc_clear got %h exp 0000", out_acc); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;  // held high early: must be ignored until out_valid rises
    send_beat(4'd7, 4'd15, 1'b0);
    send_beat(4'b1000, 4'd15, 1'b0);
    send_beat(4'd7, 4'd15, 1'b1);
    out_ready = 1'b0;
    wait_valid(10);
    checks++; if (out_acc !== 16'h005A) begin errors++; $display("FAIL b2b_acc got %h exp 005a", out_acc); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", out_ovf); end
    take_result();
  endtask

  task automatic test_backpressure();
    send_beat(4'd2, 4'd3, 1'b1);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_acc !== 16'd6) begin errors++; $display("FAIL bp_acc[%0d] got %h exp 0006", i, out_acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
    end
    take_result();
    checks++; if (out_acc !== 16'h0000) begin errors++; $display("FAIL bp_acc_clear got %h exp 0000", out_acc); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL bp_count_clear got %0d exp 0", out_count); end
  endtask

  task automatic test_reset_mid();
    send_beat(4'd3, 4'd3, 1'b0);
    send_beat(4'd2, 4'd2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", out_count); end
    checks++; if (out_acc !== 16'h0000) begin errors++; $display("FAIL midrst_acc got %h exp 0000", out_acc); end
    send_beat(4'd2, 4'd3, 1'b1);
    wait_valid(10);
    checks++; if (out_acc !== 16'd6) begin errors++; $display("FAIL midrst_res_acc got %h exp 0006", out_acc); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL midrst_res_count got %0d exp 1", out_count); end
    take_result();
  endtask

  task automatic test_overflow8();
    logic [7:0] exp_acc;
`ifdef WALLACE_MAC_SAT_EN
    exp_acc = 8'h7F;
`else
    exp_acc = 8'hA4;
`endif
    for (int i = 0; i < 4; i++) send_beat8(4'd7, 4'd15, i == 3);
    begin
      int n = 0;
      while (out_valid8 !== 1'b1 && n < 10) begin step(); n++; end
    end
    checks++; if (out_valid8 !== 1'b1) begin errors++; $display("FAIL ovf8_valid got %b exp 1", out_valid8); end
    checks++; if (out_acc8 !== exp_acc) begin errors++; $display("FAIL ovf8_acc got %h exp %h", out_acc8, exp_acc); end
    checks++; if (out_ovf8 !== 1'b1) begin errors++; $display("FAIL ovf8_ovf got %b exp 1", out_ovf8); end
    checks++; if (out_count8 !== 8'd4) begin errors++; $display("FAIL ovf8_count got %0d exp 4", out_count8); end
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    checks++; if (out_ovf8 !== 1'b0) begin errors++; $display("FAIL ovf8_ovf_clear got %b exp 0", out_ovf8); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 255; i++) send_beat(4'b1000, 4'd15, i == 254);
    wait_valid(10);
    checks++; if (out_acc !== 16'h8878) begin errors++; $display("FAIL ext255_acc got %h exp 8878", out_acc); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL ext255_count got %0d exp 255", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ext255_ovf got %b exp 0", out_ovf); end
    take_result();
    for (int i = 0; i < 256; i++) send_beat(4'b1000, 4'd15, i == 255);
    wait_valid(10);
    checks++; if (out_acc !== 16'h8800) begin errors++; $display("FAIL ext256_acc got %h exp 8800", out_acc); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL ext256_count got %0d exp 255", out_count); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ext256_ovf got %b exp 0", out_ovf); end
    take_result();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_a = 4'd0; in_b = 4'd0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_last8 = 1'b0; in_a8 = 4'd0; in_b8 = 4'd0; out_ready8 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_overflow8();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
